// File: rtl/wm8731_iic_slave.sv
`timescale 1ns/1ps
// wm8731_iic_slave
// I2C target emulating the write-only WM8731 control port. It decodes the
// 3-byte writes {DEV_ADDR,W}, {reg[6:0],data[8]}, {data[7:0]}, ACKs them
// on open-drain SDA and keeps a WM8731-compatible register file (R0..R9,
// with R15 acting as "reset to defaults").
//
// Parameters:
//   DEV_ADDR  7-bit target address matched in the first byte
//   FILT_LEN  glitch-filter stability length in clk_in cycles
//             (present only with WM8731_IIC_SLAVE_GLITCH_FILTER_EN)
// Ports:
//   clk_in    system clock (>= 20x SCL rate)
//   rst       synchronous active-high reset
//   SCL       I2C clock from master
//   SDA       I2C data, pulled low for ACK, otherwise released (z)
//   rd_addr   register-file read index
//   rd_data   combinational read of rd_addr, 0 for unmapped indexes
//   wr_valid  one-cycle pulse per committed write
//   wr_addr   register address of the last committed write
//   wr_data   data of the last committed write
//   busy      high between START and STOP
// Configuration macro:
//   WM8731_IIC_SLAVE_GLITCH_FILTER_EN  adds a stability filter on the
//   synchronized SCL/SDA before edge and START/STOP detection.

module wm8731_iic_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'b0011_010
`ifdef WM8731_IIC_SLAVE_GLITCH_FILTER_EN
   ,parameter int unsigned FILT_LEN = 3
`endif
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEV, S_ACK0, S_HI, S_ACK1, S_LO, S_ACK2, S_NACK
    } state_t;

    localparam logic [8:0] REG_DEFAULTS [0:9] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    state_t     r_state, w_state_nxt;

    logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic       w_scl, w_sda;
    logic       r_scl_d, r_sda_d;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic       w_data_st, w_ack_st, w_byte_done, w_commit;

    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_hi;
    logic       r_wr_valid;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic       r_busy;
    logic [8:0] r_regs [0:9];

    // ---------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= SCL;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= SDA;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef WM8731_IIC_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILT_LEN + 1);

    logic [FW-1:0] r_scl_fcnt, r_sda_fcnt;
    logic          r_scl_f, r_sda_f;

    // Output follows the input only after FILT_LEN consecutive cycles of
    // disagreement; any return to the old value restarts the count.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_fcnt <= '0;
            r_sda_fcnt <= '0;
        end else begin
            if (r_scl_s2 != r_scl_f) begin
                if (r_scl_fcnt == FW'(FILT_LEN - 1)) begin
                    r_scl_f    <= r_scl_s2;
                    r_scl_fcnt <= '0;
                end else begin
                    r_scl_fcnt <= r_scl_fcnt + 1'b1;
                end
            end else begin
                r_scl_fcnt <= '0;
            end
            if (r_sda_s2 != r_sda_f) begin
                if (r_sda_fcnt == FW'(FILT_LEN - 1)) begin
                    r_sda_f    <= r_sda_s2;
                    r_sda_fcnt <= '0;
                end else begin
                    r_sda_fcnt <= r_sda_fcnt + 1'b1;
                end
            end else begin
                r_sda_fcnt <= '0;
            end
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign w_data_st   = (r_state == S_DEV) || (r_state == S_HI) || (r_state == S_LO);
    assign w_ack_st    = (r_state == S_ACK0) || (r_state == S_ACK1) || (r_state == S_ACK2);
    assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_commit    = (r_state == S_ACK2) && w_scl_fall;

    // ACK pull-down is gated by rst so the bus is released immediately
    assign SDA = (w_ack_st && !rst) ? 1'b0 : 1'bz;

    // ---------------------------------------------------------------
    // State machine
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_DEV;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_DEV:  if (w_byte_done)
                            w_state_nxt = (r_shift == {DEV_ADDR, 1'b0}) ? S_ACK0 : S_NACK;
                S_ACK0: if (w_scl_fall)  w_state_nxt = S_HI;
                S_HI:   if (w_byte_done) w_state_nxt = S_ACK1;
                S_ACK1: if (w_scl_fall)  w_state_nxt = S_LO;
                S_LO:   if (w_byte_done) w_state_nxt = S_ACK2;
                S_ACK2: if (w_scl_fall)  w_state_nxt = S_NACK;
                S_NACK: w_state_nxt = S_NACK;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Datapath and register file
    // ---------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_hi       <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_regs     <= REG_DEFAULTS;
        end else begin
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_wr_valid <= w_commit;

            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;

            if (w_start || w_stop)
                r_bit_cnt <= '0;
            else if (w_data_st && w_scl_rise)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            else if (w_data_st && w_byte_done)
                r_bit_cnt <= '0;

            if (w_data_st && w_scl_rise)
                r_shift <= {r_shift[6:0], w_sda};

            if ((r_state == S_HI) && w_byte_done)
                r_hi <= r_shift;

            // r_shift still holds the low data byte while in S_ACK2
            if (w_commit) begin
                r_wr_addr <= r_hi[7:1];
                r_wr_data <= {r_hi[0], r_shift};
                if (r_hi[7:1] < 7'd10)
                    r_regs[r_hi[4:1]] <= {r_hi[0], r_shift};
                else if (r_hi[7:1] == 7'd15)
                    r_regs <= REG_DEFAULTS;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < 4'd10)
            rd_data = r_regs[rd_addr];
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;

endmodule

// File: tb/tb_wm8731_iic_slave.sv
`timescale 1ns/1ps
// Bench for wm8731_iic_slave: a behavioural I2C master drives writes,
// expected commits are queued as stimulus goes out and compared whenever
// wr_valid pulses; register contents are compared against a local model.

module tb_wm8731_iic_slave;

    localparam int unsigned Q = 300;   // quarter SCL period in ns

    typedef struct packed {
        logic [6:0] a;
        logic [8:0] d;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       scl    = 1'b1;
    logic       m_sda  = 1'b1;
    logic [3:0] rd_addr = '0;
    logic [8:0] rd_data;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    wire        sda;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        exp_q[$];
    logic [8:0]  m_reg [0:9];
    logic [8:0]  defaults [0:9];

    wm8731_iic_slave #(.DEV_ADDR(7'b0011_010)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .SCL     (scl),
        .SDA     (sda),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #10 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_reg[i] = defaults[i];
    endtask

    task automatic expect_wr(input logic [6:0] a, input logic [8:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        if (a < 7'd10) m_reg[a] = d;
        else if (a == 7'd15) model_reset();
    endtask

    // Scoreboard consumer
    always @(negedge clk_in) begin
        if (!rst && wr_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {25'd0, wr_addr}, {25'd0, e.a});
                chk("wr_data", {23'd0, wr_data}, {23'd0, e.d});
            end
        end
    end

    task automatic rd_chk(input logic [3:0] a, input logic [8:0] exp, input string tag);
        rd_addr = a;
        @(negedge clk_in);
        chk(tag, {23'd0, rd_data}, {23'd0, exp});
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl   = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl   = 1'b1; #Q;
        m_sda = 1'b1; #Q;
        #Q;
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q;
            scl   = 1'b1; #Q; #Q;
            scl   = 1'b0; #Q;
        end
    endtask

    task automatic ack_clock(output logic ack);
        m_sda = 1'b1; #Q;
        scl   = 1'b1; #Q;
        ack   = (sda == 1'b0);
        #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic a;
        send_bits(b);
        ack_clock(a);
        chk(tag, {31'd0, a}, {31'd0, exp_ack});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        defaults = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                     9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        model_reset();

        // Reset state
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_sda",      {31'd0, sda},      1);
        chk("rst_busy",     {31'd0, busy},     0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 0);
        chk("rst_wr_addr",  {25'd0, wr_addr},  0);
        chk("rst_wr_data",  {23'd0, wr_data},  0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) rd_chk(4'(i), defaults[i], "rst_rd");
        rd_chk(4'd10, 9'h000, "rd_unmapped10");
        rd_chk(4'd15, 9'h000, "rd_unmapped15");

        // Basic write R2 = 0x07F
        i2c_start();
        chk("busy_mid", {31'd0, busy}, 1);
        send_byte(8'h34, 1'b1, "t1_ack0");
        send_byte(8'h04, 1'b1, "t1_ack1");
        expect_wr(7'd2, 9'h07F);
        send_byte(8'h7F, 1'b1, "t1_ack2");
        i2c_stop();
        chk("t1_busy_after_stop", {31'd0, busy}, 0);
        rd_chk(4'd2, m_reg[2], "t1_rd2");
        chk("t1_wr_addr_hold", {25'd0, wr_addr}, 2);

        // Wrong address, then read bit set: never ACKed, no commit
        i2c_start();
        send_byte(8'h36, 1'b0, "t2_nack_addr");
        send_byte(8'h04, 1'b0, "t2_nack_b1");
        send_byte(8'h11, 1'b0, "t2_nack_b2");
        i2c_stop();
        i2c_start();
        send_byte(8'h35, 1'b0, "t2_nack_rd");
        send_byte(8'h04, 1'b0, "t2_nack_rd_b1");
        i2c_stop();
        rd_chk(4'd2, m_reg[2], "t2_rd2");

        // R7 = 0, then R15 reloads defaults
        i2c_start();
        send_byte(8'h34, 1'b1, "t3a_ack0");
        send_byte(8'h0E, 1'b1, "t3a_ack1");
        expect_wr(7'd7, 9'h000);
        send_byte(8'h00, 1'b1, "t3a_ack2");
        i2c_stop();
        rd_chk(4'd7, 9'h000, "t3_rd7_cleared");
        i2c_start();
        send_byte(8'h34, 1'b1, "t3b_ack0");
        send_byte(8'h1E, 1'b1, "t3b_ack1");
        expect_wr(7'd15, 9'h000);
        send_byte(8'h00, 1'b1, "t3b_ack2");
        i2c_stop();
        rd_chk(4'd7, 9'h00A, "t3_rd7_default");
        rd_chk(4'd0, 9'h097, "t3_rd0_default");
        rd_chk(4'd2, 9'h079, "t3_rd2_default");

        // Repeated START aborts the first transaction
        i2c_start();
        send_byte(8'h34, 1'b1, "t4_ack0a");
        send_byte(8'h08, 1'b1, "t4_ack1a");
        i2c_start();
        send_byte(8'h34, 1'b1, "t4_ack0b");
        send_byte(8'h0C, 1'b1, "t4_ack1b");
        expect_wr(7'd6, 9'h09E);
        send_byte(8'h9E, 1'b1, "t4_ack2b");
        i2c_stop();
        rd_chk(4'd4, 9'h00A, "t4_rd4_unchanged");
        rd_chk(4'd6, m_reg[6], "t4_rd6");

        // Fourth byte is NACKed, single commit
        i2c_start();
        send_byte(8'h34, 1'b1, "t5_ack0");
        send_byte(8'h01, 1'b1, "t5_ack1");
        expect_wr(7'd0, 9'h1FF);
        send_byte(8'hFF, 1'b1, "t5_ack2");
        send_byte(8'h55, 1'b0, "t5_nack3");
        i2c_stop();
        rd_chk(4'd0, 9'h1FF, "t5_rd0");

        // Reset while ACKing the high byte
        i2c_start();
        send_byte(8'h34, 1'b1, "t6_ack0");
        send_bits(8'h04);
        m_sda = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            seen = (sda == 1'b0);
        end
        chk("t6_ack1_driven", {31'd0, seen}, 1);
        rst = 1'b1;
        #1;
        chk("t6_sda_released_now", {31'd0, sda}, 1);
        @(posedge clk_in);
        #1;
        chk("t6_sda_released", {31'd0, sda},  1);
        chk("t6_busy",         {31'd0, busy}, 0);
        rst = 1'b0;
        model_reset();
        rd_chk(4'd0, 9'h097, "t6_rd0_default");
        rd_chk(4'd6, 9'h09F, "t6_rd6_default");
        i2c_stop();
        i2c_start();
        send_byte(8'h34, 1'b1, "t6_ack0b");
        send_byte(8'h0A, 1'b1, "t6_ack1b");
        expect_wr(7'd5, 9'h055);
        send_byte(8'h55, 1'b1, "t6_ack2b");
        i2c_stop();
        rd_chk(4'd5, 9'h055, "t6_rd5");
        chk("t6_busy_end", {31'd0, busy}, 0);

        repeat (10) @(negedge clk_in);
        chk("pending_commits", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
